// File: rtl/mdu_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_unit_if
//  Description : E-stage MDU bus. The pipeline side drives the opcode and the
//                forwarded operands. The MDU side returns the hazard signals,
//                the move-from result and the HI/LO registers.
//  Revision    : 1.0  initial release
// ============================================================================
interface mdu_unit_if;
    logic [3:0]  E_MDU_Op;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic        E_MDU_Start;
    logic        E_MDU_Busy;
    logic [31:0] E_MDU_Out;
    logic [31:0] HI_out;
    logic [31:0] LO_out;

    modport master (
        output E_MDU_Op, E_rs_data, E_rt_data,
        input  E_MDU_Start, E_MDU_Busy, E_MDU_Out, HI_out, LO_out
    );

    modport slave (
        input  E_MDU_Op, E_rs_data, E_rt_data,
        output E_MDU_Start, E_MDU_Busy, E_MDU_Out, HI_out, LO_out
    );
endinterface
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_unit
//  Description : Multi-cycle multiply/divide unit with HI/LO registers.
//                The result is computed when the op starts and held in
//                temporary registers. It is committed to HI/LO after a fixed
//                busy window, which models the latency of the operation.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire           clk,
    input  wire           reset,
    mdu_unit_if.slave     bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;
    localparam logic [3:0] c_op_mfhi  = 4'd7;
    localparam logic [3:0] c_op_mflo  = 4'd8;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t             r_state,  w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               r_wr_en,  w_wr_en_nxt;
    logic [31:0]        r_hi,     w_hi_nxt;
    logic [31:0]        r_lo,     w_lo_nxt;
    logic [31:0]        r_tmp_hi, w_tmp_hi_nxt;
    logic [31:0]        r_tmp_lo, w_tmp_lo_nxt;

    logic [31:0] w_a, w_b;
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_a_neg, w_b_neg, w_b_zero;
    logic [31:0] w_ub, w_abs_a, w_abs_b, w_mq, w_mr, w_sq, w_sr, w_uq, w_ur;
    logic        w_is_md;

    assign w_a      = bus.E_rs_data;
    assign w_b      = bus.E_rt_data;
    assign w_is_md  = (bus.E_MDU_Op >= c_op_mult) && (bus.E_MDU_Op <= c_op_divu);

    // Datapath: products and quotients of the current operands.
    // Signed division works on magnitudes. This makes 0x80000000 / -1 come
    // out as 0x80000000 instead of overflowing. A zero divisor is replaced by
    // 1 so that the divider never sees zero; that result is discarded anyway.
    assign w_prod_s = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});
    assign w_prod_u = {32'd0, w_a} * {32'd0, w_b};
    assign w_a_neg  = w_a[31];
    assign w_b_neg  = w_b[31];
    assign w_b_zero = (w_b == 32'd0);
    assign w_ub     = w_b_zero ? 32'd1 : w_b;
    assign w_abs_a  = w_a_neg ? (32'd0 - w_a) : w_a;
    assign w_abs_b  = w_b_zero ? 32'd1 : (w_b_neg ? (32'd0 - w_b) : w_b);
    assign w_mq     = w_abs_a / w_abs_b;
    assign w_mr     = w_abs_a % w_abs_b;
    assign w_sq     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_mq) : w_mq;
    assign w_sr     = w_a_neg ? (32'd0 - w_mr) : w_mr;
    assign w_uq     = w_a / w_ub;
    assign w_ur     = w_a % w_ub;

    // State register, with an asynchronous clear of all architectural and temporary state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_wr_en  <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_tmp_hi <= w_tmp_hi_nxt;
            r_tmp_lo <= w_tmp_lo_nxt;
        end
    end

    // Next-state logic: start ops and moves in IDLE, count down and commit in BUSY.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = r_busy;
        w_wr_en_nxt  = r_wr_en;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_tmp_hi_nxt = r_tmp_hi;
        w_tmp_lo_nxt = r_tmp_lo;
        case (r_state)
            S_IDLE: begin
                if (w_is_md) begin
                    w_state_nxt = S_BUSY;
                    w_busy_nxt  = 1'b1;
                    w_wr_en_nxt = 1'b1;
                    w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                    case (bus.E_MDU_Op)
                        c_op_mult:  {w_tmp_hi_nxt, w_tmp_lo_nxt} = w_prod_s;
                        c_op_multu: {w_tmp_hi_nxt, w_tmp_lo_nxt} = w_prod_u;
                        c_op_div: begin
                            w_tmp_hi_nxt = w_sr;
                            w_tmp_lo_nxt = w_sq;
                            w_cnt_nxt    = CNT_W'(DIV_CYCLES);
                            w_wr_en_nxt  = !w_b_zero;
                        end
                        default: begin
                            w_tmp_hi_nxt = w_ur;
                            w_tmp_lo_nxt = w_uq;
                            w_cnt_nxt    = CNT_W'(DIV_CYCLES);
                            w_wr_en_nxt  = !w_b_zero;
                        end
                    endcase
                end else if (bus.E_MDU_Op == c_op_mthi) begin
                    w_hi_nxt = w_a;
                end else if (bus.E_MDU_Op == c_op_mtlo) begin
                    w_lo_nxt = w_a;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    if (r_wr_en) begin
                        w_hi_nxt = r_tmp_hi;
                        w_lo_nxt = r_tmp_lo;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: the start strobe and move-from read are combinational, busy comes from a register.
    always_comb begin
        bus.E_MDU_Start = w_is_md && (r_state == S_IDLE);
        bus.E_MDU_Busy  = r_busy;
        bus.HI_out      = r_hi;
        bus.LO_out      = r_lo;
        bus.E_MDU_Out   = 32'd0;
        if (bus.E_MDU_Op == c_op_mfhi)
            bus.E_MDU_Out = r_hi;
        else if (bus.E_MDU_Op == c_op_mflo)
            bus.E_MDU_Out = r_lo;
    end
endmodule
`default_nettype wire
